// File: rtl/vend_dispense_arbiter_if.sv
// Bundle of request, grant and inventory signals between the vending
// front-ends (master) and the dispense arbiter (slave).
interface vend_dispense_arbiter_if #(
    parameter int N_REQ   = 2,
    parameter int STOCK_W = 4
) ();
    logic [N_REQ-1:0]   req_valid;
    logic [2*N_REQ-1:0] req_item;
    logic               restock;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   deny;
    logic [1:0]         motor;
    logic               busy;
    logic [1:0]         cur_state;
    logic [STOCK_W-1:0] stock_water;
    logic [STOCK_W-1:0] stock_coke;

    modport master (
        output req_valid, req_item, restock,
        input  gnt, deny, motor, busy, cur_state, stock_water, stock_coke
    );

    modport slave (
        input  req_valid, req_item, restock,
        output gnt, deny, motor, busy, cur_state, stock_water, stock_coke
    );
endinterface

// File: rtl/vend_dispense_arbiter.sv
// Round-robin arbiter sharing one drink dispenser between N_REQ front-ends.
// Grants a vend when the requested item is in stock (driving the motor for
// DISP_CYCLES cycles), otherwise denies; follows every decision with a
// single cooldown cycle. Keeps per-item stock counters with restock reload.
module vend_dispense_arbiter #(
    parameter int N_REQ       = 2,
    parameter int DISP_CYCLES = 4,
    parameter int STOCK_W     = 4,
    parameter int STOCK_INIT  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    vend_dispense_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam logic [1:0] ITEM_NONE  = 2'b00;
    localparam logic [1:0] ITEM_WATER = 2'b01;
    localparam logic [1:0] ITEM_COKE  = 2'b10;
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        DISPENSE = 2'b01,
        COOLDOWN = 2'b10
    } state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   ptr_reg, ptr_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [1:0]         item_reg, item_next;
    logic [N_REQ-1:0]   gnt_reg, gnt_next;
    logic [N_REQ-1:0]   deny_reg, deny_next;
    logic [1:0]         motor_reg, motor_next;
    logic               busy_reg, busy_next;
    logic [STOCK_W-1:0] water_reg, water_next;
    logic [STOCK_W-1:0] coke_reg, coke_next;

    logic [1:0]         item_arr [N_REQ];
    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [1:0]         win_item;
    logic               item_ok;
    logic               dec_water;
    logic               dec_coke;
    int                 idx_tmp;

    // Split the packed item bus into one code per requester.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_item
            assign item_arr[gi] = bus.req_item[2*gi+1 -: 2];
        end
    endgenerate

    // Round-robin search: the lowest offset from ptr with a pending request wins.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        idx_tmp = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_tmp = int'(ptr_reg) + k;
            if (idx_tmp >= N_REQ) idx_tmp = idx_tmp - N_REQ;
            if (bus.req_valid[idx_tmp]) begin
                found  = 1'b1;
                winner = PTR_W'(idx_tmp);
            end
        end
        win_item = item_arr[winner];
        item_ok  = ((win_item == ITEM_WATER) && (water_reg != '0)) ||
                   ((win_item == ITEM_COKE)  && (coke_reg  != '0));
    end

    // FSM next-state, grant/deny pulses, motor drive and stock bookkeeping.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        item_next  = item_reg;
        gnt_next   = '0;
        deny_next  = '0;
        dec_water  = 1'b0;
        dec_coke   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    ptr_next = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
                    if (item_ok) begin
                        gnt_next   = ONE_HOT0 << winner;
                        item_next  = win_item;
                        cnt_next   = CNT_W'(DISP_CYCLES - 1);
                        state_next = DISPENSE;
                        dec_water  = (win_item == ITEM_WATER);
                        dec_coke   = (win_item == ITEM_COKE);
                    end else begin
                        deny_next  = ONE_HOT0 << winner;
                        state_next = COOLDOWN;
                    end
                end
            end
            DISPENSE: begin
                if (cnt_reg == '0) state_next = COOLDOWN;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            COOLDOWN: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        motor_next = (state_next == DISPENSE) ? item_next : ITEM_NONE;
        busy_next  = (state_next != IDLE);
        if (bus.restock) begin
            water_next = dec_water ? STOCK_W'(STOCK_INIT - 1) : STOCK_W'(STOCK_INIT);
            coke_next  = dec_coke  ? STOCK_W'(STOCK_INIT - 1) : STOCK_W'(STOCK_INIT);
        end else begin
            water_next = water_reg - STOCK_W'(dec_water);
            coke_next  = coke_reg  - STOCK_W'(dec_coke);
        end
    end

    // State and output registers; reset drops any vend in flight and refills stock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            item_reg  <= ITEM_NONE;
            gnt_reg   <= '0;
            deny_reg  <= '0;
            motor_reg <= ITEM_NONE;
            busy_reg  <= 1'b0;
            water_reg <= STOCK_W'(STOCK_INIT);
            coke_reg  <= STOCK_W'(STOCK_INIT);
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            item_reg  <= item_next;
            gnt_reg   <= gnt_next;
            deny_reg  <= deny_next;
            motor_reg <= motor_next;
            busy_reg  <= busy_next;
            water_reg <= water_next;
            coke_reg  <= coke_next;
        end
    end

    assign bus.gnt         = gnt_reg;
    assign bus.deny        = deny_reg;
    assign bus.motor       = motor_reg;
    assign bus.busy        = busy_reg;
    assign bus.cur_state   = state_reg;
    assign bus.stock_water = water_reg;
    assign bus.stock_coke  = coke_reg;
endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Directed bench for vend_dispense_arbiter: N_REQ=2, DISP_CYCLES=4, STOCK_INIT=2.
// Inputs change and outputs are sampled on the falling edge.
module tb_vend_dispense_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    vend_dispense_arbiter_if #(.N_REQ(2), .STOCK_W(4)) bus ();

    vend_dispense_arbiter #(
        .N_REQ(2), .DISP_CYCLES(4), .STOCK_W(4), .STOCK_INIT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_item  = 4'b0000;
        bus.restock   = 1'b0;
        nxt(); nxt();
        chk("rst_gnt",   8'(bus.gnt), 8'h0);
        chk("rst_deny",  8'(bus.deny), 8'h0);
        chk("rst_motor", 8'(bus.motor), 8'h0);
        chk("rst_busy",  8'(bus.busy), 8'h0);
        chk("rst_state", 8'(bus.cur_state), 8'h0);
        chk("rst_water", 8'(bus.stock_water), 8'h2);
        chk("rst_coke",  8'(bus.stock_coke), 8'h2);
        rst = 1'b0;
        $display("step A: reset state checked");

        // B: req0 water
        bus.req_valid = 2'b01; bus.req_item = 4'b0001;
        nxt();
        chk("b_gnt",   8'(bus.gnt), 8'h1);
        chk("b_state", 8'(bus.cur_state), 8'h1);
        chk("b_busy",  8'(bus.busy), 8'h1);
        chk("b_motor", 8'(bus.motor), 8'h1);
        chk("b_water", 8'(bus.stock_water), 8'h1);
        bus.req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("b_motor_hold", 8'(bus.motor), 8'h1);
            chk("b_gnt_low",    8'(bus.gnt), 8'h0);
        end
        nxt();
        chk("b_cd_motor", 8'(bus.motor), 8'h0);
        chk("b_cd_state", 8'(bus.cur_state), 8'h2);
        chk("b_cd_busy",  8'(bus.busy), 8'h1);
        nxt();
        chk("b_idle_state", 8'(bus.cur_state), 8'h0);
        chk("b_idle_busy",  8'(bus.busy), 8'h0);
        $display("step B: req0 water grant and dispense");

        // C: req1 invalid item 11 (ptr=1) -> deny, ptr back to 0
        bus.req_valid = 2'b10; bus.req_item = 4'b1100;
        nxt();
        chk("c_deny",  8'(bus.deny), 8'h2);
        chk("c_gnt",   8'(bus.gnt), 8'h0);
        chk("c_state", 8'(bus.cur_state), 8'h2);
        chk("c_motor", 8'(bus.motor), 8'h0);
        chk("c_water", 8'(bus.stock_water), 8'h1);
        chk("c_coke",  8'(bus.stock_coke), 8'h2);
        bus.req_valid = 2'b00;
        nxt();
        chk("c_idle", 8'(bus.cur_state), 8'h0);
        chk("c_deny_low", 8'(bus.deny), 8'h0);
        $display("step C: req1 invalid item denied");

        // D: both coke with ptr=0
        bus.req_valid = 2'b11; bus.req_item = 4'b1010;
        nxt();
        chk("d_gnt0",   8'(bus.gnt), 8'h1);
        chk("d_coke1",  8'(bus.stock_coke), 8'h1);
        chk("d_motor0", 8'(bus.motor), 8'h2);
        bus.req_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("d_motor_hold0", 8'(bus.motor), 8'h2);
        end
        nxt();
        chk("d_cd0", 8'(bus.cur_state), 8'h2);
        chk("d_cd0_gnt", 8'(bus.gnt), 8'h0);
        nxt();
        chk("d_idle0", 8'(bus.cur_state), 8'h0);
        nxt();
        chk("d_gnt1",   8'(bus.gnt), 8'h2);
        chk("d_coke0",  8'(bus.stock_coke), 8'h0);
        chk("d_motor1", 8'(bus.motor), 8'h2);
        bus.req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("d_motor_hold1", 8'(bus.motor), 8'h2);
        end
        nxt();
        chk("d_cd1", 8'(bus.cur_state), 8'h2);
        nxt();
        chk("d_idle1", 8'(bus.cur_state), 8'h0);
        $display("step D: two coke requests served round-robin");

        // E: req1 coke while sold out
        bus.req_valid = 2'b10; bus.req_item = 4'b1000;
        nxt();
        chk("e_deny",  8'(bus.deny), 8'h2);
        chk("e_gnt",   8'(bus.gnt), 8'h0);
        chk("e_motor", 8'(bus.motor), 8'h0);
        chk("e_coke",  8'(bus.stock_coke), 8'h0);
        chk("e_state", 8'(bus.cur_state), 8'h2);
        bus.req_valid = 2'b00;
        nxt();
        chk("e_idle", 8'(bus.cur_state), 8'h0);
        $display("step E: sold-out coke denied");

        // F: req0 invalid codes 11 and 00
        bus.req_valid = 2'b01; bus.req_item = 4'b0011;
        nxt();
        chk("f11_deny",  8'(bus.deny), 8'h1);
        chk("f11_water", 8'(bus.stock_water), 8'h1);
        chk("f11_coke",  8'(bus.stock_coke), 8'h0);
        bus.req_valid = 2'b00;
        nxt();
        bus.req_valid = 2'b01; bus.req_item = 4'b0000;
        nxt();
        chk("f00_deny",  8'(bus.deny), 8'h1);
        chk("f00_water", 8'(bus.stock_water), 8'h1);
        bus.req_valid = 2'b00;
        nxt();
        chk("f_idle", 8'(bus.cur_state), 8'h0);
        $display("step F: invalid item codes denied");

        // G: restock during dispense
        bus.req_valid = 2'b01; bus.req_item = 4'b0001;
        nxt();
        chk("g_gnt",   8'(bus.gnt), 8'h1);
        chk("g_water", 8'(bus.stock_water), 8'h0);
        bus.req_valid = 2'b00;
        nxt();
        chk("g_motor2", 8'(bus.motor), 8'h1);
        bus.restock = 1'b1;
        nxt();
        bus.restock = 1'b0;
        chk("g_rs_water", 8'(bus.stock_water), 8'h2);
        chk("g_rs_coke",  8'(bus.stock_coke), 8'h2);
        chk("g_motor3",   8'(bus.motor), 8'h1);
        chk("g_state3",   8'(bus.cur_state), 8'h1);
        nxt();
        chk("g_motor4", 8'(bus.motor), 8'h1);
        nxt();
        chk("g_cd_motor", 8'(bus.motor), 8'h0);
        chk("g_cd_state", 8'(bus.cur_state), 8'h2);
        nxt();
        chk("g_idle", 8'(bus.cur_state), 8'h0);
        $display("step G: restock during dispense");

        // H: restock on the same edge as a water grant
        bus.req_valid = 2'b01; bus.req_item = 4'b0001; bus.restock = 1'b1;
        nxt();
        bus.req_valid = 2'b00; bus.restock = 1'b0;
        chk("h_gnt",   8'(bus.gnt), 8'h1);
        chk("h_water", 8'(bus.stock_water), 8'h1);
        chk("h_coke",  8'(bus.stock_coke), 8'h2);
        repeat (4) nxt();
        chk("h_cd", 8'(bus.cur_state), 8'h2);
        nxt();
        chk("h_idle", 8'(bus.cur_state), 8'h0);
        $display("step H: restock coincident with grant");

        // I: asynchronous reset in cycle 2 of dispense
        bus.req_valid = 2'b01; bus.req_item = 4'b0010;
        nxt();
        chk("i_gnt",  8'(bus.gnt), 8'h1);
        chk("i_coke", 8'(bus.stock_coke), 8'h1);
        bus.req_valid = 2'b00;
        nxt();
        chk("i_motor2", 8'(bus.motor), 8'h2);
        #2 rst = 1'b1;
        #1;
        chk("i_rst_motor", 8'(bus.motor), 8'h0);
        chk("i_rst_gnt",   8'(bus.gnt), 8'h0);
        chk("i_rst_state", 8'(bus.cur_state), 8'h0);
        chk("i_rst_busy",  8'(bus.busy), 8'h0);
        chk("i_rst_water", 8'(bus.stock_water), 8'h2);
        chk("i_rst_coke",  8'(bus.stock_coke), 8'h2);
        nxt();
        rst = 1'b0;
        bus.req_valid = 2'b11; bus.req_item = 4'b0101;
        nxt();
        chk("i_post_gnt",   8'(bus.gnt), 8'h1);
        chk("i_post_water", 8'(bus.stock_water), 8'h1);
        chk("i_post_motor", 8'(bus.motor), 8'h1);
        bus.req_valid = 2'b00;
        repeat (6) nxt();
        chk("i_end_idle", 8'(bus.cur_state), 8'h0);
        $display("step I: async reset mid-dispense and recovery");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vend_dispense_arbiter.md
# vend_dispense_arbiter

Shares a single drink-dispense mechanism between N_REQ vending front-ends. Each front-end presents a request with a 2-bit item code; the block arbitrates round-robin, checks per-item stock, and either grants (driving the dispense motor for a fixed number of cycles) or denies. It sits between the vending FSM instances and the physical dispenser and tracks inventory.

## Interface
- N_REQ, 2, number of requesting front-ends (≥2)
- DISP_CYCLES, 4, cycles the motor is driven per vend (≥1)
- STOCK_W, 4, width of each stock counter
- STOCK_INIT, 3, stock loaded on reset and on restock (< 2^STOCK_W)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  request pending, bit i per front-end
- req_item  in  2*N_REQ  item code of requester i at [2i+1:2i]; 01=water, 10=coke, 00/11 invalid
- restock  in  1  single-cycle pulse, reload both stock counters
- gnt  out  N_REQ  one-hot, one-cycle grant pulse
- deny  out  N_REQ  one-hot, one-cycle deny pulse (sold out or invalid item)
- motor  out  2  dispense drive, item code while dispensing, else 00
- busy  out  1  high whenever state != IDLE
- cur_state  out  2  IDLE=00, DISPENSE=01, COOLDOWN=10
- stock_water  out  STOCK_W  remaining water count
- stock_coke  out  STOCK_W  remaining coke count

## Operation
- Reset values: gnt=0, deny=0, motor=00, busy=0, cur_state=00, stock_water=stock_coke=STOCK_INIT, round-robin pointer ptr=0, dispense counter=0.
- Requester protocol: hold req_valid and req_item stable until gnt or deny seen; drop req_valid in the cycle gnt/deny is high. req_valid still high when the block returns to IDLE is a new request.
- Arbitration (IDLE only): winner = first i at or after ptr (mod N_REQ) with req_valid[i]=1. No request → stay IDLE.
- Winner evaluation uses stock values before the edge:
  - item invalid, or item's stock = 0 → deny[winner]=1 next cycle, go COOLDOWN, stock unchanged.
  - otherwise → gnt[winner]=1 next cycle, latch item, decrement its stock, load counter, go DISPENSE.
  - either way ptr ← winner+1 mod N_REQ.
- DISPENSE: motor = latched item for exactly DISP_CYCLES cycles, then go COOLDOWN.
- COOLDOWN: one cycle, motor=00, requests ignored, then IDLE.
- Restock: on the edge where restock=1, both counters ← STOCK_INIT; if that same edge also decrements (grant), the granted item's counter ← STOCK_INIT−1. Restock is accepted in any state and does not disturb the FSM.
- Stock counters never wrap: a zero count always denies, so no decrement below 0.
- Requests in DISPENSE/COOLDOWN are not sampled; they wait.

## Timing
- Edge k: IDLE sees request. Cycle k+1: gnt (or deny) high for 1 cycle, cur_state=01 (or 10), busy=1, stock updated.
- Grant path: motor active cycles k+1 … k+DISP_CYCLES; COOLDOWN at cycle k+DISP_CYCLES+1; IDLE at k+DISP_CYCLES+2; earliest next gnt/deny at k+DISP_CYCLES+3.
- Deny path: COOLDOWN at k+1, IDLE at k+2, next gnt/deny earliest k+3.
- All outputs registered; no combinational input-to-output paths.
- rst asserted mid-operation: all outputs and internal state return to reset values immediately (asynchronously), motor=00 without waiting for the edge; in-flight vend is dropped and stock is reloaded.

## Test plan
(N_REQ=2, DISP_CYCLES=4, STOCK_INIT=2)
- Reset, req0 water for 1 request → gnt=01 one cycle after sampling, motor=01 for exactly 4 cycles, stock_water 2→1, one COOLDOWN cycle (cur_state=10), then cur_state=00, busy=0.
- req0 and req1 both coke on the same edge, ptr=0 → gnt=01 first, motor=10 ×4, cooldown, then gnt=10; stock_coke 2→1→0; ptr ends at 0.
- Third coke request from req1 with stock_coke=0 → deny=10 one cycle, motor stays 00, stock_coke stays 0, cur_state=10 for 1 cycle then 00.
- req0 item=11 → deny=01, no stock change; req0 item=00 → deny=01.
- restock pulse during DISPENSE → stocks = 2 next cycle, motor continues to full 4 cycles; restock on the same edge as a water grant → stock_water=1, stock_coke=2.
- rst asserted in cycle 2 of DISPENSE → motor=00, gnt=0, cur_state=00, stocks=2 immediately; after release a fresh request from req0 is granted with normal latency.
